lms6_tx_feeder: RTL and testbench
=================================

LMS6_TX_FEEDER -- requirements
Module: lms6_tx_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the sample FIFO depth (power of two, at least 4).
REQ-002 The block SHALL have parameter PREFILL, default 8, meaning the FIFO level (1..DEPTH) required before streaming starts.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: streaming enable.
REQ-006 The block SHALL have port s_data, input, 24 bits: upstream sample, I in [23:12] and Q in [11:0].
REQ-007 The block SHALL have port s_valid, input, 1 bit: upstream sample valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-009 The block SHALL have port tx_ready, input, 1 bit: the downstream interleaver is in its Q phase; the next edge starts a new I/Q frame.
REQ-010 The block SHALL have port tx_data, output, 24 bits: registered sample presented to the interleaver.
REQ-011 The block SHALL have port running, output, 1 bit: high in state RUN.
REQ-012 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port underrun_cnt, output, 16 bits: count of underrun events, saturating.

Function
REQ-014 A push SHALL occur when s_valid && s_ready; s_ready SHALL equal (state != IDLE) && (level < DEPTH), based on registered level, with no same-cycle pop credit.
REQ-015 tx_data SHALL be a register that changes only on an edge where tx_ready=1, so each sample is held for the full two-cycle I/Q frame.
REQ-016 States SHALL be IDLE, PREFILL and RUN, with a 2-bit encoding.
REQ-017 IDLE: tx_data SHALL load 24'h000000 on tx_ready; the FIFO SHALL be held empty; the block SHALL go to PREFILL when en=1.
REQ-018 PREFILL: tx_data SHALL load zero on tx_ready; the block SHALL go to RUN on the edge at which level (after update) >= PREFILL.
REQ-019 RUN with tx_ready=1 and level>0: the block SHALL pop the FIFO head into tx_data, one pop per edge.
REQ-020 RUN with tx_ready=1 and level=0 is an underrun: tx_data SHALL load zero, underrun_cnt SHALL increment (saturating at 16'hFFFF), and the block SHALL go to PREFILL.
REQ-021 On an underrun, a push arriving in the same cycle SHALL be stored and SHALL NOT bypass to tx_data.
REQ-022 Level SHALL update as level + push - pop; a simultaneous push and pop SHALL leave level unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 en=0 in any state SHALL force IDLE on the next edge; the FIFO SHALL be flushed (pointers and level to 0) on that edge, any in-flight push SHALL be discarded, and underrun_cnt SHALL be retained.
REQ-025 A transition to IDLE SHALL NOT be counted as an underrun.
REQ-026 Data order SHALL be strictly FIFO, with no sample dropped or duplicated while en stays high.

Reset
REQ-027 On rst, the block SHALL enter IDLE with tx_data=0, level=0, pointers=0, underrun_cnt=0, running=0 and s_ready=0.
REQ-028 rst SHALL take priority over all other inputs; a reset mid-stream SHALL discard FIFO contents.
REQ-029 FIFO storage SHALL need no reset.

Structure
REQ-030 Shared package lms6_pkg SHALL hold SAMPLE_W=24, IQ_W=12, I_MSB/I_LSB/Q_MSB/Q_LSB, ZERO_SAMPLE and the feeder state enum.
REQ-031 The block SHALL have one sub-module, sync_fifo (parameterised width/depth, push/pop, level), instantiated once; the state machine, tx_data register and counter SHALL live in lms6_tx_feeder.

Verification
REQ-032 Basic: rst, then en=1; push 8 samples 0x001001..0x008008 back-to-back; tx_ready toggling 0/1 -> running rises when level reaches 8; tx_data then steps 0x001001, 0x002002, ..., with each value held 2 cycles.
REQ-033 Underrun: after REQ-032 stop pushing -> the 9th tx_ready edge loads 0x000000, underrun_cnt=1, state PREFILL, running=0; 8 further pushes resume RUN.
REQ-034 Full: hold s_valid=1 with tx_ready=0 -> level stops at 16 and s_ready=0; a push while full is not accepted; a pop then re-enables s_ready the following cycle.
REQ-035 Simultaneous: in RUN at level=5, push and pop on the same edge -> level stays 5 and order is preserved.
REQ-036 Disable: drop en mid-stream at level=6 -> next edge IDLE, level=0, tx_data zero from the next tx_ready, underrun_cnt unchanged.
REQ-037 Saturation: force 65536 underruns -> underrun_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/lms6_pkg.sv
// Shared constants, sample layout and feeder state encoding for the LMS6 TX path.
package lms6_pkg;

    localparam int SAMPLE_W = 24;
    localparam int IQ_W     = 12;
    localparam int I_MSB    = 23;
    localparam int I_LSB    = 12;
    localparam int Q_MSB    = 11;
    localparam int Q_LSB    = 0;

    localparam logic [SAMPLE_W-1:0] ZERO_SAMPLE = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } feeder_state_t;

    function automatic logic [SAMPLE_W-1:0] pack_iq(input logic [IQ_W-1:0] i_val,
                                                   input logic [IQ_W-1:0] q_val);
        logic [SAMPLE_W-1:0] s;
        s = ZERO_SAMPLE;
        s[I_MSB:I_LSB] = i_val;
        s[Q_MSB:Q_LSB] = q_val;
        return s;
    endfunction

endpackage

// File: rtl/lms6_tx_feeder_if.sv
// Upstream sample handshake, interleaver side and status of the TX feeder.
interface lms6_tx_feeder_if #(
    parameter int DEPTH = 16
);
    import lms6_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                en;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                tx_ready;
    logic [SAMPLE_W-1:0] tx_data;
    logic                running;
    logic [LVL_W-1:0]    level;
    logic [15:0]         underrun_cnt;

    modport master (
        output en, s_data, s_valid, tx_ready,
        input  s_ready, tx_data, running, level, underrun_cnt
    );

    modport slave (
        input  en, s_data, s_valid, tx_ready,
        output s_ready, tx_data, running, level, underrun_cnt
    );

endinterface

// File: rtl/lms6_tx_feeder_fifo.sv
// Single-clock FIFO with occupancy output; flush clears pointers and drops any push.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (level < LW'(DEPTH));
    assign pop_ok  = pop && (level != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/lms6_tx_feeder.sv
// Buffers upstream I/Q samples and feeds one per interleaver frame, zero-filling on underrun.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | disabled; FIFO held empty, zeros sent to the interleaver
//   ST_PREFILL | collecting samples until PREFILL are buffered; zeros sent
//   ST_RUN     | one FIFO sample per frame; empty FIFO at frame start = underrun
module lms6_tx_feeder
    import lms6_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic              clk,
    input  logic              rst,
    lms6_tx_feeder_if.slave   bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    feeder_state_t       state_q;
    feeder_state_t       state_d;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    level_next;
    logic [SAMPLE_W-1:0] head;
    logic [SAMPLE_W-1:0] tx_data_q;
    logic [15:0]         ur_cnt_q;
    logic                push;
    logic                pop;
    logic                flush;
    logic                underrun;

    // Ready uses the registered level only; a same-edge pop never frees a slot early.
    assign bus.s_ready = (state_q != ST_IDLE) && (level < LVL_W'(DEPTH));
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.en && (state_q == ST_RUN) && bus.tx_ready && (level != '0);
    assign underrun    = bus.en && (state_q == ST_RUN) && bus.tx_ready && (level == '0);
    assign flush       = !bus.en || (state_q == ST_IDLE);
    assign level_next  = level + LVL_W'(push) - LVL_W'(pop);

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.s_data),
        .rd_data (head),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_PREFILL;
                ST_PREFILL: if (level_next >= LVL_W'(PREFILL)) state_d = ST_RUN;
                ST_RUN:     if (underrun) state_d = ST_PREFILL;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // The interleaver latches I then Q, so tx_data may only move at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= ZERO_SAMPLE;
        end else if (bus.tx_ready) begin
            tx_data_q <= pop ? head : ZERO_SAMPLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ur_cnt_q <= '0;
        end else if (underrun && (ur_cnt_q != 16'hFFFF)) begin
            ur_cnt_q <= ur_cnt_q + 16'd1;
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.running      = (state_q == ST_RUN);
    assign bus.level        = level;
    assign bus.underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_lms6_tx_feeder.sv
// Scoreboard bench for lms6_tx_feeder: behavioural model plus directed scenarios and random traffic.
module tb_lms6_tx_feeder;
    import lms6_pkg::*;

    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lms6_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    lms6_tx_feeder #(
        .DEPTH   (DEPTH),
        .PREFILL (PREFILL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                  checks = 0;
    int                  errors = 0;
    logic [SAMPLE_W-1:0] sb [$];
    feeder_state_t       m_state;
    logic [SAMPLE_W-1:0] m_tx;
    logic [15:0]         m_ur;
    int                  next_k;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [SAMPLE_W-1:0] smp(input int k);
        logic [IQ_W-1:0] v;
        v = k[IQ_W-1:0];
        return pack_iq(v, v);
    endfunction

    // One clock: sample driven inputs, advance the model at the edge, compare #1 later.
    task automatic tick();
        bit                  en_s = bus.en;
        bit                  v    = bus.s_valid;
        bit                  tr   = bus.tx_ready;
        bit                  r    = rst;
        logic [SAMPLE_W-1:0] d    = bus.s_data;
        bit                  acc  = 1'b0;
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_state = ST_IDLE;
            m_tx    = '0;
            m_ur    = '0;
        end else if (!en_s) begin
            sb.delete();
            m_state = ST_IDLE;
            if (tr) m_tx = '0;
        end else begin
            acc = v && (m_state != ST_IDLE) && (sb.size() < DEPTH);
            case (m_state)
                ST_IDLE: begin
                    if (tr) m_tx = '0;
                    m_state = ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (tr) m_tx = '0;
                    if (acc) sb.push_back(d);
                    if (sb.size() >= PREFILL) m_state = ST_RUN;
                end
                default: begin
                    if (tr) begin
                        if (sb.size() > 0) begin
                            m_tx = sb.pop_front();
                        end else begin
                            m_tx = '0;
                            if (m_ur != 16'hFFFF) m_ur = m_ur + 16'd1;
                            m_state = ST_PREFILL;
                        end
                    end
                    if (acc) sb.push_back(d);
                end
            endcase
        end
        #1;
        chk("tx_data", bus.tx_data, m_tx);
        chk("level", bus.level, sb.size());
        chk("running", bus.running, m_state == ST_RUN);
        chk("s_ready", bus.s_ready, (m_state != ST_IDLE) && (sb.size() < DEPTH));
        chk("underrun_cnt", bus.underrun_cnt, m_ur);
        if (acc) next_k++;
    endtask

    task automatic cyc(input bit v, input bit tog);
        bus.s_valid = v;
        bus.s_data  = smp(next_k);
        tick();
        if (tog) bus.tx_ready = ~bus.tx_ready;
    endtask

    task automatic push_n(input int n, input bit tog);
        int target = next_k + n;
        int guard  = 0;
        while (next_k < target && guard < 200) begin
            cyc(1'b1, tog);
            guard++;
        end
        chk("push_done", next_k, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.tx_ready = 1'b0;
        next_k       = 1;
        m_state      = ST_IDLE;
        m_tx         = '0;
        m_ur         = '0;

        repeat (3) cyc(1'b1, 1'b1);
        chk("rst_tx", bus.tx_data, 24'h000000);
        chk("rst_sready", bus.s_ready, 1'b0);
        rst          = 1'b0;
        bus.tx_ready = 1'b0;

        // Basic streaming then underrun after the eighth sample.
        bus.en = 1'b1;
        cyc(1'b0, 1'b1);
        push_n(8, 1'b1);
        chk("basic_running", bus.running, 1'b1);
        chk("basic_level", bus.level, 8);
        repeat (20) cyc(1'b0, 1'b1);
        chk("ur_count_one", bus.underrun_cnt, 16'd1);
        chk("ur_not_running", bus.running, 1'b0);
        push_n(8, 1'b1);
        chk("resume_running", bus.running, 1'b1);

        // Full: no frames, keep offering samples.
        bus.tx_ready = 1'b0;
        repeat (12) cyc(1'b1, 1'b0);
        chk("full_level", bus.level, 16);
        chk("full_sready", bus.s_ready, 1'b0);
        bus.tx_ready = 1'b1;
        cyc(1'b1, 1'b0);
        chk("full_sready_back", bus.s_ready, 1'b1);
        bus.tx_ready = 1'b0;

        // Drain to 5, then push and pop on the same edge.
        for (int g = 0; g < 100 && sb.size() > 5; g++) cyc(1'b0, 1'b1);
        chk("drain_to_5", sb.size(), 5);
        bus.tx_ready = 1'b1;
        cyc(1'b1, 1'b0);
        chk("simul_level", bus.level, 5);
        bus.tx_ready = 1'b0;

        // Disable mid-stream at level 6.
        cyc(1'b1, 1'b0);
        chk("dis_pre_level", bus.level, 6);
        bus.en = 1'b0;
        cyc(1'b1, 1'b0);
        chk("dis_level", bus.level, 0);
        chk("dis_running", bus.running, 1'b0);
        chk("dis_ur_kept", bus.underrun_cnt, 16'd1);
        bus.tx_ready = 1'b1;
        cyc(1'b0, 1'b0);
        chk("dis_tx_zero", bus.tx_data, 24'h000000);
        bus.tx_ready = 1'b0;

        // Random traffic with occasional disables.
        bus.en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            bus.en       = ($urandom_range(0, 63) != 0);
            cyc($urandom_range(0, 3) != 0, 1'b0);
        end

        // Reset mid-stream discards everything.
        bus.en       = 1'b1;
        bus.tx_ready = 1'b0;
        push_n(10, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_level", bus.level, 0);
        chk("midrst_ur", bus.underrun_cnt, 16'd0);

        // Saturation: preload the counter near the top, then cause three underruns.
        bus.en       = 1'b0;
        bus.tx_ready = 1'b0;
        cyc(1'b0, 1'b0);
        force dut.ur_cnt_q = 16'hFFFD;
        #1;
        release dut.ur_cnt_q;
        m_ur = 16'hFFFD;
        cyc(1'b0, 1'b0);
        bus.en = 1'b1;
        repeat (3) begin
            push_n(8, 1'b1);
            repeat (24) cyc(1'b0, 1'b1);
        end
        chk("sat_hold", bus.underrun_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
